// File: rtl/cpu_div_pkg.sv
// Shared definitions for the execute-stage integer divider.
package cpu_div_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_WIDTH = XLEN;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;
endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, select.
module div_radix2_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-2:0] i_rem,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH:0]   w_trial;

  assign w_partial = {i_rem, i_q_msb};
  assign w_trial   = {1'b0, w_partial} - {1'b0, i_dvs};
  assign o_q_bit   = ~w_trial[WIDTH];
  assign o_rem     = w_trial[WIDTH] ? w_partial : w_trial[WIDTH-1:0];
endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Signed operands are divided as magnitudes and the signs are fixed up on entry to DONE.
module div_radix2
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dnd;
  logic [WIDTH-1:0] r_dvs;
  // Partial remainder stays below 2^(WIDTH-1) until the final step, so WIDTH-1 bits suffice.
  logic [WIDTH-2:0] r_rem;
  logic             r_qneg, r_rneg;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_dbz;

  logic             w_accept, w_last, w_dvs_zero;
  logic             w_dnd_neg, w_dvs_neg;
  logic [WIDTH-1:0] w_dnd_mag, w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt, w_q_nxt;
  logic             w_q_bit;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  assign w_accept   = in_ready & in_valid & ~flush;
  assign w_last     = (r_state == CALC) & (r_cnt == LAST);
  assign w_dvs_zero = (divisor == '0);
  assign w_dnd_neg  = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
  assign w_dnd_mag  = w_dnd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
  assign w_q_nxt    = {r_dnd[WIDTH-2:0], w_q_bit};

  div_radix2_step #(.WIDTH(WIDTH)) u_step (
    .i_rem   (r_rem),
    .i_q_msb (r_dnd[WIDTH-1]),
    .i_dvs   (r_dvs),
    .o_rem   (w_rem_nxt),
    .o_q_bit (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_dvs_zero ? DONE : CALC;
      CALC:    if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_dnd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_dnd  <= w_dnd_mag;
      r_dvs  <= w_dvs_mag;
      r_rem  <= '0;
      r_qneg <= w_dnd_neg ^ w_dvs_neg;
      r_rneg <= w_dnd_neg;
      if (w_dvs_zero) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end
    end else if ((r_state == CALC) && !flush) begin
      r_cnt <= r_cnt + 1'b1;
      r_dnd <= w_q_nxt;
      r_rem <= w_rem_nxt[WIDTH-2:0];
      if (w_last) begin
        r_quotient  <= r_qneg ? -w_q_nxt : w_q_nxt;
        r_remainder <= r_rneg ? -w_rem_nxt : w_rem_nxt;
        r_dbz       <= 1'b0;
      end
    end
  end
endmodule
